// File: rtl/writeback_stage.sv
// writeback_stage: single register-file write port shared by the ALU/load path
// and the multi-cycle M-extension unit. ALU results always win; colliding
// M-unit results wait in a small in-order FIFO and drain in ALU bubbles.
// Outputs are registered so the register file sees at most one write per cycle.
module writeback_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       alu_word,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [4:0]                 md_rd,
    input  logic [XLEN-1:0]            md_data,
    input  logic                       md_word,
    output logic [4:0]                 rd,
    output logic                       wr_en,
    output logic [XLEN-1:0]            wr_data,
    output logic                       md_busy,
    output logic [$clog2(DEPTH):0]     md_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // *W results carry a 32-bit value that must be sign-extended to XLEN
    function automatic logic signed [XLEN-1:0] sext_word(
        input logic signed [XLEN-1:0] d,
        input logic                   w
    );
        logic signed [31:0] lo;
        lo = d[31:0];
        return w ? XLEN'(lo) : d;
    endfunction

    // FIFO storage (data only, never reset) and control state
    logic [4:0]             fifo_rd   [DEPTH];
    logic [XLEN-1:0]        fifo_data [DEPTH];
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [CNT_W-1:0]       count;

    // selection stage (p0) signals, registered into the outputs
    logic                   md_acc_p0;
    logic signed [XLEN-1:0] alu_ext_p0;
    logic signed [XLEN-1:0] md_ext_p0;
    logic                   push_p0;
    logic                   pop_p0;
    logic                   vld_p0;
    logic [4:0]             sel_rd_p0;
    logic [XLEN-1:0]        sel_data_p0;

    assign md_ready   = (count < FULL_CNT);
    assign md_busy    = (count != '0);
    assign md_count   = count;
    assign md_acc_p0  = md_valid && md_ready;
    assign alu_ext_p0 = sext_word(alu_data, alu_word);
    assign md_ext_p0  = sext_word(md_data, md_word);

    // priority select: ALU, then FIFO head, then M-unit bypass
    always_comb begin
        push_p0     = 1'b0;
        pop_p0      = 1'b0;
        vld_p0      = 1'b0;
        sel_rd_p0   = alu_rd;
        sel_data_p0 = alu_ext_p0;
        if (alu_valid) begin
            vld_p0      = 1'b1;
            push_p0     = md_acc_p0;
        end else if (count != '0) begin
            vld_p0      = 1'b1;
            pop_p0      = 1'b1;
            push_p0     = md_acc_p0;
            sel_rd_p0   = fifo_rd[rptr];
            sel_data_p0 = fifo_data[rptr];
        end else if (md_acc_p0) begin
            vld_p0      = 1'b1;
            sel_rd_p0   = md_rd;
            sel_data_p0 = md_ext_p0;
        end
    end

    // FIFO entry write on push; storage holds already-extended data
    always_ff @(posedge clk) begin
        if (push_p0) begin
            fifo_rd[wptr]   <= md_rd;
            fifo_data[wptr] <= md_ext_p0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_p0) wptr <= wptr + PTR_W'(1);
            if (pop_p0)  rptr <= rptr + PTR_W'(1);
            if (push_p0 && !pop_p0)
                count <= count + CNT_W'(1);
            else if (pop_p0 && !push_p0)
                count <= count - CNT_W'(1);
        end
    end

    // ---- stage boundary p0 -> register file write port ----
    // register the selected result; writes to x0 consume the slot but are gated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            rd      <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= vld_p0 && (sel_rd_p0 != 5'd0);
            if (vld_p0) begin
                rd      <= sel_rd_p0;
                wr_data <= sel_data_p0;
            end
        end
    end

endmodule
